// File: rtl/exit_gate_controller.sv
// rtl/exit_gate_controller.sv - exit gate sequencer: validate exit, open gate, pulse capacity_inc
// Optional gate-open timeout enabled by defining EXIT_TIMEOUT_EN.
module exit_gate_controller #(
  parameter logic [7:0] CAPACITY    = 8'd200,
  parameter int         OPEN_CYCLES = 16,
  parameter int         TMR_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       exit_i,
  input  logic [7:0] parking_capacity_i,
  input  logic       sensor_clear_i,
  output logic       gate_open_o,
  output logic       capacity_inc_o,
  output logic       exit_reject_o,
  output logic       timeout_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic gate_open_q,    gate_open_d;
  logic capacity_inc_q, capacity_inc_d;
  logic exit_reject_q,  exit_reject_d;
  logic busy_q,         busy_d;
  logic timeout_d;
  logic lot_empty;
  logic expired;

  // A counter reading above CAPACITY is a fault and is treated as an empty lot.
  assign lot_empty = (parking_capacity_i >= CAPACITY);

`ifdef EXIT_TIMEOUT_EN
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q;

  // Timer is held at zero outside OPEN and saturates instead of wrapping.
  always_comb begin
    timer_d = timer_q;
    if (state_q != S_OPEN) begin
      timer_d = '0;
    end else if (timer_q != {TMR_W{1'b1}}) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  assign expired = (timer_q == TMR_W'(OPEN_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign expired   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      gate_open_q    <= 1'b0;
      capacity_inc_q <= 1'b0;
      exit_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      gate_open_q    <= gate_open_d;
      capacity_inc_q <= capacity_inc_d;
      exit_reject_q  <= exit_reject_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (exit_i) begin
          state_d = lot_empty ? S_HOLD : S_OPEN;
        end
      end
      S_OPEN: begin
        // sensor_clear takes priority over a simultaneous expiry
        if (sensor_clear_i) begin
          state_d = S_DONE;
        end else if (expired) begin
          state_d = S_HOLD;
        end
      end
      S_DONE: state_d = S_HOLD;
      S_HOLD: begin
        if (!exit_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they align with it.
  always_comb begin
    gate_open_d    = (state_d == S_OPEN);
    capacity_inc_d = (state_d == S_DONE);
    exit_reject_d  = (state_q == S_IDLE) && exit_i && lot_empty;
    timeout_d      = (state_q == S_OPEN) && !sensor_clear_i && expired;
    busy_d         = (state_d != S_IDLE);
  end

  assign gate_open_o    = gate_open_q;
  assign capacity_inc_o = capacity_inc_q;
  assign exit_reject_o  = exit_reject_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_exit_gate_controller.sv
// tb/tb_exit_gate_controller.sv - scoreboard bench for exit_gate_controller
module tb_exit_gate_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       exit_r = 1'b0;
  logic [7:0] cap = 8'd0;
  logic       sc = 1'b0;
  logic       gate, inc, rej, tmo, busy;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  int         m_state = 0;
  int         m_cnt = 0;

`ifdef EXIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  exit_gate_controller dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .exit_i             (exit_r),
    .parking_capacity_i (cap),
    .sensor_clear_i     (sc),
    .gate_open_o        (gate),
    .capacity_inc_o     (inc),
    .exit_reject_o      (rej),
    .timeout_o          (tmo),
    .busy_o             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour; returns {gate_open, capacity_inc, exit_reject, timeout, busy}
  task automatic model(input logic e, input logic [7:0] c, input logic s, output logic [4:0] exp);
    logic r, t;
    r = 1'b0;
    t = 1'b0;
    case (m_state)
      0: if (e) begin
           if (c < 8'd200) begin
             m_state = 1;
             m_cnt = 0;
           end else begin
             m_state = 3;
             r = 1'b1;
           end
         end
      1: if (s) m_state = 2;
         else if (TO_EN && m_cnt == 15) begin
           m_state = 3;
           t = 1'b1;
         end else if (m_cnt < 255) m_cnt++;
      2: m_state = 3;
      default: if (!e) m_state = 0;
    endcase
    exp = {m_state == 1, m_state == 2, r, t, m_state != 0};
  endtask

  task automatic step(input string tag, input logic e, input logic [7:0] c, input logic s);
    logic [4:0] exp;
    exit_r = e;
    cap = c;
    sc = s;
    model(e, c, s, exp);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    chk(tag, {gate, inc, rej, tmo, busy}, exp_q.pop_front());
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {gate, inc, rej, tmo, busy}, 5'b0);
    rst_n = 1'b1;

    // mid-OPEN async reset
    step("rst_start", 1'b1, 8'd100, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("rst_open%0d", i), 1'b0, 8'd100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gate_drop", gate, 1'b0);
    chk("rst_busy_drop", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_state = 0;
    m_cnt = 0;
    for (int i = 0; i < 4; i++) step($sformatf("rst_after%0d", i), 1'b0, 8'd100, 1'b1);

    // normal exit, sensor_clear at cycle 5
    step("t2_c0", 1'b1, 8'd150, 1'b0);
    for (int i = 1; i <= 4; i++) step($sformatf("t2_c%0d", i), 1'b0, 8'd150, 1'b0);
    step("t2_c5", 1'b0, 8'd150, 1'b1);
    for (int i = 6; i <= 8; i++) step($sformatf("t2_c%0d", i), 1'b0, 8'd150, 1'b0);

    // lot empty, exit held
    for (int i = 0; i < 10; i++) step($sformatf("t3_c%0d", i), 1'b1, 8'd200, 1'b0);
    step("t3_rel", 1'b0, 8'd200, 1'b0);
    step("t3_idle", 1'b0, 8'd200, 1'b0);

    // no sensor_clear: times out when enabled, else waits
    step("t4_c0", 1'b1, 8'd100, 1'b0);
    for (int i = 1; i <= 20; i++) step($sformatf("t4_c%0d", i), 1'b0, 8'd100, 1'b0);
    step("t4_sc", 1'b0, 8'd100, 1'b1);
    for (int i = 0; i < 3; i++) step($sformatf("t4_tail%0d", i), 1'b0, 8'd100, 1'b0);

    // sensor_clear on the expiry cycle
    step("t5_c0", 1'b1, 8'd100, 1'b0);
    for (int i = 1; i <= 15; i++) step($sformatf("t5_c%0d", i), 1'b0, 8'd100, 1'b0);
    step("t5_c16", 1'b0, 8'd100, 1'b1);
    for (int i = 17; i <= 19; i++) step($sformatf("t5_c%0d", i), 1'b0, 8'd100, 1'b0);

    // exit held through transaction, then re-armed
    for (int i = 0; i < 3; i++) step($sformatf("t6_a%0d", i), 1'b1, 8'd150, 1'b0);
    step("t6_sc", 1'b1, 8'd150, 1'b1);
    for (int i = 0; i < 5; i++) step($sformatf("t6_b%0d", i), 1'b1, 8'd150, i[0]);
    step("t6_rel0", 1'b0, 8'd150, 1'b0);
    step("t6_rel1", 1'b0, 8'd150, 1'b0);
    step("t6_again", 1'b1, 8'd150, 1'b0);
    step("t6_sc2", 1'b1, 8'd150, 1'b1);
    step("t6_end0", 1'b0, 8'd150, 1'b0);
    step("t6_end1", 1'b0, 8'd150, 1'b0);

    // capacity boundaries and fault values
    step("b199", 1'b1, 8'd199, 1'b0);
    step("b199_sc", 1'b0, 8'd199, 1'b1);
    step("b199_t", 1'b0, 8'd199, 1'b0);
    step("b199_i", 1'b0, 8'd199, 1'b0);
    step("b201", 1'b1, 8'd201, 1'b0);
    step("b201_r", 1'b0, 8'd201, 1'b0);
    step("b255", 1'b1, 8'd255, 1'b0);
    step("b255_r", 1'b0, 8'd255, 1'b0);
    step("b0", 1'b1, 8'd0, 1'b0);
    step("b0_capchg", 1'b0, 8'd255, 1'b0);
    step("b0_sc", 1'b0, 8'd255, 1'b1);
    step("b0_t", 1'b0, 8'd0, 1'b0);
    step("b0_i", 1'b0, 8'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
